// File: rtl/jpeg_sof_gen.sv
// Baseline JPEG SOF0 segment generator: streams the 19-byte marker segment for a
// latched frame config over valid/ready and reports the MCU grid for that frame.
module jpeg_sof_gen (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] cfg_width,
  input  logic [15:0] cfg_height,
  input  logic        cfg_411,
  input  logic [1:0]  cfg_y_qt,
  input  logic [1:0]  cfg_cr_qt,
  input  logic [1:0]  cfg_cb_qt,
  output logic        out_valid,
  output logic [7:0]  out_data,
  output logic        out_last,
  input  logic        out_ready,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [13:0] mcu_w,
  output logic [13:0] mcu_h
);

  localparam logic [4:0] LAST_IDX = 5'd18;

  typedef enum logic {S_IDLE, S_EMIT} state_e;

  typedef struct packed {
    logic [15:0] w;
    logic [15:0] h;
    logic        s411;
    logic [1:0]  y_qt;
    logic [1:0]  cr_qt;
    logic [1:0]  cb_qt;
  } cfg_t;

  state_e      state_q, state_d;
  cfg_t        cfg_in, cfg_q, cfg_d;
  logic [4:0]  idx_q, idx_d;
  logic        vld_q, vld_d;
  logic [7:0]  data_q, data_d;
  logic        last_q, last_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [13:0] mcuw_q, mcuw_d;
  logic [13:0] mcuh_q, mcuh_d;

  logic        dims_ok;
  logic        accept;
  logic        hs;
  logic [4:0]  idx_nxt;

  assign cfg_in  = '{w: cfg_width, h: cfg_height, s411: cfg_411,
                     y_qt: cfg_y_qt, cr_qt: cfg_cr_qt, cb_qt: cfg_cb_qt};
  assign dims_ok = (cfg_width != 16'd0) && (cfg_height != 16'd0);
  assign accept  = (state_q == S_IDLE) && start && dims_ok;
  assign hs      = vld_q && out_ready;
  assign idx_nxt = idx_q + 5'd1;

  // Component 2 carries the Cr table and component 3 the Cb table, matching
  // the decoder parser's field mapping so headers round-trip.
  function automatic logic [7:0] seg_byte(input logic [4:0] i, input cfg_t c);
    logic [7:0] b;
    case (i)
      5'd0:    b = 8'hFF;
      5'd1:    b = 8'hC0;
      5'd2:    b = 8'h00;
      5'd3:    b = 8'h11;
      5'd4:    b = 8'h08;
      5'd5:    b = c.h[15:8];
      5'd6:    b = c.h[7:0];
      5'd7:    b = c.w[15:8];
      5'd8:    b = c.w[7:0];
      5'd9:    b = 8'h03;
      5'd10:   b = 8'h01;
      5'd11:   b = c.s411 ? 8'h22 : 8'h11;
      5'd12:   b = {6'b0, c.y_qt};
      5'd13:   b = 8'h02;
      5'd14:   b = 8'h11;
      5'd15:   b = {6'b0, c.cr_qt};
      5'd16:   b = 8'h03;
      5'd17:   b = 8'h11;
      5'd18:   b = {6'b0, c.cb_qt};
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  // Ceiling division by the MCU edge (16 for 2x2 luma sampling, 8 otherwise).
  function automatic logic [13:0] mcu_dim(input logic [15:0] v, input logic s411);
    logic [13:0] r;
    if (s411) r = {2'b0, v[15:4]} + {13'b0, |v[3:0]};
    else      r = {1'b0, v[15:3]} + {13'b0, |v[2:0]};
    return r;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_EMIT;
      S_EMIT:  if (hs && last_q) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cfg_d  = cfg_q;
    idx_d  = idx_q;
    vld_d  = vld_q;
    data_d = data_q;
    last_d = last_q;
    busy_d = busy_q;
    mcuw_d = mcuw_q;
    mcuh_d = mcuh_q;
    done_d = 1'b0;
    err_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (dims_ok) begin
            cfg_d  = cfg_in;
            idx_d  = 5'd0;
            vld_d  = 1'b1;
            busy_d = 1'b1;
            data_d = seg_byte(5'd0, cfg_in);
            last_d = 1'b0;
            mcuw_d = mcu_dim(cfg_width, cfg_411);
            mcuh_d = mcu_dim(cfg_height, cfg_411);
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_EMIT: begin
        if (hs) begin
          if (last_q) begin
            idx_d  = 5'd0;
            vld_d  = 1'b0;
            busy_d = 1'b0;
            data_d = 8'h00;
            last_d = 1'b0;
            done_d = 1'b1;
          end else begin
            idx_d  = idx_nxt;
            data_d = seg_byte(idx_nxt, cfg_q);
            last_d = (idx_nxt == LAST_IDX);
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cfg_q  <= '0;
      idx_q  <= 5'd0;
      vld_q  <= 1'b0;
      data_q <= 8'h00;
      last_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      mcuw_q <= 14'd0;
      mcuh_q <= 14'd0;
    end else begin
      cfg_q  <= cfg_d;
      idx_q  <= idx_d;
      vld_q  <= vld_d;
      data_q <= data_d;
      last_q <= last_d;
      busy_q <= busy_d;
      done_q <= done_d;
      err_q  <= err_d;
      mcuw_q <= mcuw_d;
      mcuh_q <= mcuh_d;
    end
  end

  assign out_valid = vld_q;
  assign out_data  = data_q;
  assign out_last  = last_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign mcu_w     = mcuw_q;
  assign mcu_h     = mcuh_q;

endmodule

// File: tb/tb_jpeg_sof_gen.sv
// Bench for jpeg_sof_gen: table of frame configs, hand-written corner sequences,
// and randomized configs/backpressure against a byte-list reference model.
module tb_jpeg_sof_gen;

  logic        clk = 1'b0;
  logic        rst, start, cfg_411, out_ready;
  logic [15:0] cfg_width, cfg_height;
  logic [1:0]  cfg_y_qt, cfg_cr_qt, cfg_cb_qt;
  logic        out_valid, out_last, busy, done, err;
  logic [7:0]  out_data;
  logic [13:0] mcu_w, mcu_h;

  jpeg_sof_gen dut (
    .clk(clk), .rst(rst), .start(start),
    .cfg_width(cfg_width), .cfg_height(cfg_height), .cfg_411(cfg_411),
    .cfg_y_qt(cfg_y_qt), .cfg_cr_qt(cfg_cr_qt), .cfg_cb_qt(cfg_cb_qt),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
    .out_ready(out_ready), .busy(busy), .done(done), .err(err),
    .mcu_w(mcu_w), .mcu_h(mcu_h)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] w;
    logic [15:0] h;
    logic        s411;
    logic [1:0]  yq;
    logic [1:0]  crq;
    logic [1:0]  cbq;
  } cfg_t;

  typedef struct {
    cfg_t c;
    int   mw;
    int   mh;
  } vec_t;

  typedef logic [18:0][7:0] seg_t;

  int vecs = 0;
  int errs = 0;
  int last_mw = 0;
  int last_mh = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: segment assembled from its field layout with plain arithmetic.
  function automatic seg_t model_seg(input cfg_t c);
    logic [7:0] q[$];
    logic [7:0] qt[3];
    seg_t r;
    int ncomp = 3;
    qt[0] = {6'b0, c.yq};
    qt[1] = {6'b0, c.crq};
    qt[2] = {6'b0, c.cbq};
    q.push_back(8'hFF);
    q.push_back(8'hC0);
    q.push_back(8'((8 + 3 * ncomp) / 256));
    q.push_back(8'((8 + 3 * ncomp) % 256));
    q.push_back(8'd8);
    q.push_back(8'(int'(c.h) / 256));
    q.push_back(8'(int'(c.h) % 256));
    q.push_back(8'(int'(c.w) / 256));
    q.push_back(8'(int'(c.w) % 256));
    q.push_back(8'(ncomp));
    for (int k = 1; k <= ncomp; k++) begin
      q.push_back(8'(k));
      q.push_back((k == 1 && c.s411) ? 8'h22 : 8'h11);
      q.push_back(qt[k-1]);
    end
    for (int i = 0; i < 19; i++) r[i] = q[i];
    return r;
  endfunction

  function automatic int mcu_of(input int v, input bit s411);
    int b = s411 ? 16 : 8;
    return (v + b - 1) / b;
  endfunction

  task automatic drive_cfg(input cfg_t c);
    cfg_width  = c.w;
    cfg_height = c.h;
    cfg_411    = c.s411;
    cfg_y_qt   = c.yq;
    cfg_cr_qt  = c.crq;
    cfg_cb_qt  = c.cbq;
  endtask

  function automatic cfg_t rand_cfg();
    cfg_t c;
    c.w    = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom_range(1, 65535));
    c.h    = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom_range(1, 65535));
    c.s411 = 1'($urandom_range(0, 1));
    c.yq   = 2'($urandom_range(0, 3));
    c.crq  = 2'($urandom_range(0, 3));
    c.cbq  = 2'($urandom_range(0, 3));
    return c;
  endfunction

  // Called at posedge+1 of an idle cycle; returns in the first byte cycle.
  task automatic start_seg(input cfg_t c, input bit hold);
    drive_cfg(c);
    start = 1'b1;
    @(posedge clk); #1;
    if (!hold) start = 1'b0;
    last_mw = mcu_of(int'(c.w), c.s411);
    last_mh = mcu_of(int'(c.h), c.s411);
    chk("start_busy", busy, 1);
    chk("start_valid", out_valid, 1);
    chk("mcu_w", mcu_w, last_mw);
    chk("mcu_h", mcu_h, last_mh);
  endtask

  // Consumes one segment; returns in the done cycle.
  task automatic emit(input seg_t exp, input int prob, input bit stall18, input bit inject);
    int idx = 0, cyc = 0, st = 0;
    bit injd = 0, injp = 0, rdy;
    while (idx < 19 && cyc < 400) begin
      chk("valid", out_valid, 1);
      chk("data", out_data, exp[idx]);
      chk("last", out_last, idx == 18);
      chk("done_low", done, 0);
      if (injp) begin
        start = 1'b0;
        injp  = 0;
      end else if (inject && !injd && idx == 5) begin
        drive_cfg(rand_cfg());
        start = 1'b1;
        injd  = 1;
        injp  = 1;
      end
      if (stall18 && idx == 18 && st < 5) begin
        rdy = 0;
        st++;
      end else begin
        rdy = ($urandom_range(0, 99) < prob);
      end
      out_ready = rdy;
      @(posedge clk); #1;
      cyc++;
      if (rdy) idx++;
    end
    if (idx < 19) chk("emit_timeout", idx, 19);
    chk("done", done, 1);
    chk("busy_end", busy, 0);
    chk("valid_end", out_valid, 0);
  endtask

  task automatic step_done_low();
    out_ready = 1'($urandom_range(0, 1));
    @(posedge clk); #1;
    chk("done_once", done, 0);
  endtask

  vec_t tbl[7];
  seg_t lit;
  seg_t exp;
  cfg_t c;

  initial begin
    tbl[0] = '{c: '{16'd640, 16'd480, 1'b1, 2'd0, 2'd1, 2'd1}, mw: 40, mh: 30};
    tbl[1] = '{c: '{16'hFFFF, 16'd9, 1'b0, 2'd2, 2'd3, 2'd1}, mw: 8192, mh: 2};
    tbl[2] = '{c: '{16'd17, 16'd1, 1'b1, 2'd3, 2'd0, 2'd2}, mw: 2, mh: 1};
    tbl[3] = '{c: '{16'd8, 16'd8, 1'b0, 2'd1, 2'd2, 2'd3}, mw: 1, mh: 1};
    tbl[4] = '{c: '{16'd16, 16'd17, 1'b1, 2'd0, 2'd0, 2'd0}, mw: 1, mh: 2};
    tbl[5] = '{c: '{16'hFFFF, 16'hFFFF, 1'b1, 2'd3, 2'd3, 2'd3}, mw: 4096, mh: 4096};
    tbl[6] = '{c: '{16'd9, 16'd1, 1'b0, 2'd1, 2'd0, 2'd1}, mw: 2, mh: 1};
    lit = {8'h01, 8'h11, 8'h03, 8'h01, 8'h11, 8'h02, 8'h00, 8'h22, 8'h01, 8'h03,
           8'h80, 8'h02, 8'hE0, 8'h01, 8'h08, 8'h11, 8'h00, 8'hC0, 8'hFF};

    rst = 1'b1; start = 1'b0; out_ready = 1'b0;
    drive_cfg('0);
    #12;
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_last", out_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_mcu_w", mcu_w, 0);
    chk("rst_mcu_h", mcu_h, 0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 7; i++) begin
      start_seg(tbl[i].c, 0);
      chk("tbl_mcu_w", mcu_w, tbl[i].mw);
      chk("tbl_mcu_h", mcu_h, tbl[i].mh);
      exp = (i == 0) ? lit : model_seg(tbl[i].c);
      emit(exp, 100, 0, 0);
      step_done_low();
    end

    // Backpressure, long stall on the last byte, and a start while busy.
    c = tbl[1].c;
    start_seg(c, 0);
    emit(model_seg(c), 50, 1, 1);
    step_done_low();
    chk("mcu_w_after_busy_start", mcu_w, 8192);

    // Rejected starts leave everything but err alone.
    for (int k = 0; k < 2; k++) begin
      drive_cfg('{(k == 0) ? 16'd0 : 16'd100, (k == 0) ? 16'd100 : 16'd0, 1'b1, 2'd1, 2'd1, 2'd1});
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      chk("err_pulse", err, 1);
      chk("err_valid", out_valid, 0);
      chk("err_busy", busy, 0);
      chk("err_mcu_w", mcu_w, last_mw);
      chk("err_mcu_h", mcu_h, last_mh);
      for (int j = 0; j < 4; j++) begin
        @(posedge clk); #1;
        chk("err_once", err, 0);
        chk("err_no_valid", out_valid, 0);
      end
    end

    // Asynchronous reset at byte index 7.
    c = tbl[0].c;
    start_seg(c, 0);
    for (int k = 0; k < 7; k++) begin
      out_ready = 1'b1;
      @(posedge clk); #1;
    end
    chk("pre_rst_byte7", out_data, lit[7]);
    rst = 1'b1;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_data", out_data, 0);
    chk("arst_mcu_w", mcu_w, 0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_done", done, 0);
    chk("post_rst_valid", out_valid, 0);
    start_seg(c, 0);
    emit(lit, 70, 0, 0);
    step_done_low();

    // Start held high across the done cycle.
    c = tbl[2].c;
    start_seg(c, 1);
    emit(model_seg(c), 100, 0, 0);
    @(posedge clk); #1;
    start = 1'b0;
    chk("b2b_valid", out_valid, 1);
    chk("b2b_ff", out_data, 8'hFF);
    chk("b2b_busy", busy, 1);
    chk("b2b_done", done, 0);
    emit(model_seg(c), 100, 0, 0);
    step_done_low();

    for (int r = 0; r < 25; r++) begin
      c = rand_cfg();
      start_seg(c, 0);
      emit(model_seg(c), int'($urandom_range(30, 100)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)));
      step_done_low();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
